opl3_wr_sched: RTL and testbench

- Write scheduler in front of the opl3 register port.
- Buffers register writes from two requesters: A is the AdLib alias at 0x388, B is the SoundBlaster FM alias at 0x220.
- Arbitrates between A and B round-robin.
- Replays each write as a paced index-write/data-write pair on the opl3 {addr, din, we} port, so the opl3 rising-edge write detector sees clean, well-spaced pulses.

---
 rtl/opl3_wr_sched_pkg.sv | 22 ++
 rtl/opl3_wr_sched_if.sv | 29 ++
 rtl/opl3_wr_sched_fifo.sv | 52 +++++
 rtl/opl3_wr_sched.sv | 169 ++++++++++++++++
 tb/tb_opl3_wr_sched.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/opl3_wr_sched_pkg.sv
// Shared types for the opl3 write scheduler.
// Entry layout, FSM states and requester ids.
package opl3_wr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IDX,
    IDX_GAP,
    DAT,
    DAT_GAP
  } state_t;

  typedef struct packed {
    logic       bank;
    logic [7:0] index;
    logic [7:0] data;
  } wr_entry_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/opl3_wr_sched_if.sv
// Requester-side bus of the opl3 write scheduler.
// A = AdLib alias 0x388, B = SoundBlaster FM alias 0x220.
interface opl3_wr_sched_if;

  logic       a_valid;
  logic       a_ready;
  logic       a_bank;
  logic [7:0] a_index;
  logic [7:0] a_data;

  logic       b_valid;
  logic       b_ready;
  logic       b_bank;
  logic [7:0] b_index;
  logic [7:0] b_data;

  modport master (
    output a_valid, a_bank, a_index, a_data,
    output b_valid, b_bank, b_index, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_bank, a_index, a_data,
    input  b_valid, b_bank, b_index, b_data,
    output a_ready, b_ready
  );

endinterface

// File: rtl/opl3_wr_sched_fifo.sv
// Per-requester write FIFO with a registered head word.
// No push while full, even if a pop happens the same cycle.
module opl3_wr_fifo
  import opl3_wr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wr_entry_t wr_data,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wr_entry_t rd_data
);

  localparam int AW = $clog2(DEPTH);

  wr_entry_t   mem [DEPTH];
  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;
  logic [AW:0] rptr_nx;
  logic        push_ok;
  logic        pop_ok;

  assign full = (wptr_q[AW] != rptr_q[AW]) &&
                (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rptr_nx = rptr_q + {{AW{1'b0}}, pop_ok};

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q[AW-1:0]] <= wr_data;
  end

  // Head register bypasses the array when the new word lands at the head
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rd_data <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + (AW+1)'(1);
      rptr_q <= rptr_nx;
      if (push_ok && (wptr_q == rptr_nx)) rd_data <= wr_data;
      else rd_data <= mem[rptr_nx[AW-1:0]];
    end
  end

endmodule

// File: rtl/opl3_wr_sched.sv
// Round-robin write scheduler pacing index/data writes into opl3.
// OPL3_WR_SCHED_SKIP_IDX_EN: skip a repeated index phase.
module opl3_wr_sched
  import opl3_wr_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int WE_CYCLES  = 2,
  parameter int GAP_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  opl3_wr_sched_if.slave        req,
  output logic [1:0]            opl_addr,
  output logic [7:0]            opl_din,
  output logic                  opl_we,
  output logic                  busy
);

  localparam int MAXC = (WE_CYCLES > GAP_CYCLES) ?
                        WE_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] WE_LD  = CW'(WE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          last_q;
  logic          hold_bank_q;
  logic [7:0]    hold_data_q;
  logic          a_full, a_empty;
  logic          b_full, b_empty;
  logic          grant_a, grant_b;
  logic          skip;
  wr_entry_t     a_in, b_in;
  wr_entry_t     a_head, b_head, head;

  assign a_in = {req.a_bank, req.a_index, req.a_data};
  assign b_in = {req.b_bank, req.b_index, req.b_data};

  opl3_wr_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk     (clk),
    .reset   (reset),
    .push    (req.a_valid),
    .wr_data (a_in),
    .pop     (grant_a),
    .full    (a_full),
    .empty   (a_empty),
    .rd_data (a_head)
  );

  opl3_wr_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk     (clk),
    .reset   (reset),
    .push    (req.b_valid),
    .wr_data (b_in),
    .pop     (grant_b),
    .full    (b_full),
    .empty   (b_empty),
    .rd_data (b_head)
  );

  assign req.a_ready = !a_full;
  assign req.b_ready = !b_full;
  assign busy = (state_q != IDLE) || !a_empty || !b_empty;

  // Contention goes to whoever was not granted last
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == IDLE) begin
      if (!a_empty && (b_empty || last_q == REQ_B)) grant_a = 1'b1;
      else if (!b_empty) grant_b = 1'b1;
    end
  end

  assign head = grant_a ? a_head : b_head;

`ifdef OPL3_WR_SCHED_SKIP_IDX_EN
  logic       last_vld_q;
  logic       last_bank_q;
  logic [7:0] last_index_q;
  logic [7:0] hold_index_q;

  assign skip = last_vld_q &&
                ({head.bank, head.index} ==
                 {last_bank_q, last_index_q});

  always_ff @(posedge clk) begin
    if (reset) begin
      last_vld_q   <= 1'b0;
      last_bank_q  <= 1'b0;
      last_index_q <= '0;
      hold_index_q <= '0;
    end else begin
      if (grant_a || grant_b) hold_index_q <= head.index;
      if (state_q == IDX && cnt_q == '0) begin
        last_vld_q   <= 1'b1;
        last_bank_q  <= hold_bank_q;
        last_index_q <= hold_index_q;
      end
    end
  end
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= REQ_B;
      hold_bank_q <= 1'b0;
      hold_data_q <= '0;
      opl_addr    <= '0;
      opl_din     <= '0;
      opl_we      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_a || grant_b) begin
            hold_bank_q <= head.bank;
            hold_data_q <= head.data;
            last_q      <= grant_b;
            cnt_q       <= WE_LD;
            opl_we      <= 1'b1;
            if (skip) begin
              state_q  <= DAT;
              opl_addr <= {head.bank, 1'b1};
              opl_din  <= head.data;
            end else begin
              state_q  <= IDX;
              opl_addr <= {head.bank, 1'b0};
              opl_din  <= head.index;
            end
          end
        end
        IDX: begin
          if (cnt_q == '0) begin
            state_q <= IDX_GAP;
            cnt_q   <= GAP_LD;
            opl_we  <= 1'b0;
          end else cnt_q <= cnt_q - 1'b1;
        end
        IDX_GAP: begin
          if (cnt_q == '0) begin
            state_q  <= DAT;
            cnt_q    <= WE_LD;
            opl_we   <= 1'b1;
            opl_addr <= {hold_bank_q, 1'b1};
            opl_din  <= hold_data_q;
          end else cnt_q <= cnt_q - 1'b1;
        end
        DAT: begin
          if (cnt_q == '0) begin
            state_q <= DAT_GAP;
            cnt_q   <= GAP_LD;
            opl_we  <= 1'b0;
          end else cnt_q <= cnt_q - 1'b1;
        end
        DAT_GAP: begin
          if (cnt_q == '0) state_q <= IDLE;
          else cnt_q <= cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opl3_wr_sched.sv
// Directed bench for opl3_wr_sched: table of single writes
// plus arbitration, backpressure, reset and skip sequences.
module tb_opl3_wr_sched;
  import opl3_wr_pkg::*;

  typedef struct {
    logic       req;
    logic       bank;
    logic [7:0] idx;
    logic [7:0] dat;
    logic [1:0] ia;
    logic [1:0] da;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] opl_addr;
  logic [7:0] opl_din;
  logic       opl_we;
  logic       busy;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  logic [10:0] tr   [4096];
  logic        bz_tr[4096];
  logic [1:0]  rd_tr[4096];

  opl3_wr_sched_if bus ();

  opl3_wr_sched dut (
    .clk      (clk),
    .reset    (reset),
    .req      (bus),
    .opl_addr (opl_addr),
    .opl_din  (opl_din),
    .opl_we   (opl_we),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < 4096) begin
      tr[cyc]    = {opl_we, opl_addr, opl_din};
      bz_tr[cyc] = busy;
      rd_tr[cyc] = {bus.a_ready, bus.b_ready};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input wr_entry_t ae,
                       input logic bv, input wr_entry_t be,
                       output int t);
    @(negedge clk);
    t = cyc;
    bus.a_valid = av;
    {bus.a_bank, bus.a_index, bus.a_data} = ae;
    bus.b_valid = bv;
    {bus.b_bank, bus.b_index, bus.b_data} = be;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // g is the grant cycle; phases follow from g+1
  task automatic check_write(input string nm, input int g,
                             input logic [1:0] ia, input logic [1:0] da,
                             input logic [7:0] idx, input logic [7:0] dat,
                             input bit skip);
    int p;
    p = g + 1;
    chk({nm, " grant_we"}, 32'(tr[g][10]), 32'(0));
    if (!skip) begin
      for (int i = 0; i < 10; i++)
        chk($sformatf("%s idx c%0d", nm, p + i - g + 1),
            32'(tr[p+i]), 32'({i < 2, ia, idx}));
      p += 10;
    end
    for (int i = 0; i < 10; i++)
      chk($sformatf("%s dat c%0d", nm, p + i - g + 1),
          32'(tr[p+i]), 32'({i < 2, da, dat}));
  endtask

  vec_t      tbl[4];
  wr_entry_t z;
  int        t0, t;
  int        acc;
  bit        any_we;

  initial begin
    z = '0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    {bus.a_bank, bus.a_index, bus.a_data} = '0;
    {bus.b_bank, bus.b_index, bus.b_data} = '0;

    tbl[0] = '{REQ_A, 1'b0, 8'h20, 8'h01, 2'd0, 2'd1};
    tbl[1] = '{REQ_A, 1'b1, 8'h05, 8'h01, 2'd2, 2'd3};
    tbl[2] = '{REQ_B, 1'b1, 8'hFF, 8'hAA, 2'd2, 2'd3};
    tbl[3] = '{REQ_B, 1'b0, 8'h00, 8'hFF, 2'd0, 2'd1};

    do_reset();
    chk("rst opl_we", 32'(opl_we), 32'(0));
    chk("rst opl_addr", 32'(opl_addr), 32'(0));
    chk("rst opl_din", 32'(opl_din), 32'(0));
    chk("rst busy", 32'(busy), 32'(0));
    chk("rst a_ready", 32'(bus.a_ready), 32'(1));
    chk("rst b_ready", 32'(bus.b_ready), 32'(1));

    // single writes from the table
    for (int v = 0; v < 4; v++) begin
      if (tbl[v].req == REQ_A)
        drive(1'b1, {tbl[v].bank, tbl[v].idx, tbl[v].dat},
              1'b0, z, t0);
      else
        drive(1'b0, z, 1'b1,
              {tbl[v].bank, tbl[v].idx, tbl[v].dat}, t0);
      drive(1'b0, z, 1'b0, z, t);
      repeat (24) @(negedge clk);
      check_write($sformatf("vec%0d", v), t0 + 1,
                  tbl[v].ia, tbl[v].da, tbl[v].idx, tbl[v].dat, 0);
      chk($sformatf("vec%0d busy c21", v),
          32'(bz_tr[t0+21]), 32'(1));
      chk($sformatf("vec%0d busy c22", v),
          32'(bz_tr[t0+22]), 32'(0));
    end

    // arbitration: both push two entries in lockstep
    do_reset();
    drive(1'b1, {1'b0, 8'h40, 8'h11}, 1'b1, {1'b1, 8'h41, 8'h22}, t0);
    drive(1'b1, {1'b0, 8'h42, 8'h33}, 1'b1, {1'b1, 8'h43, 8'h44}, t);
    drive(1'b0, z, 1'b0, z, t);
    repeat (90) @(negedge clk);
    check_write("arb A0", t0 + 1,  2'd0, 2'd1, 8'h40, 8'h11, 0);
    check_write("arb B0", t0 + 22, 2'd2, 2'd3, 8'h41, 8'h22, 0);
    check_write("arb A1", t0 + 43, 2'd0, 2'd1, 8'h42, 8'h33, 0);
    check_write("arb B1", t0 + 64, 2'd2, 2'd3, 8'h43, 8'h44, 0);
    chk("arb busy end", 32'(bz_tr[t0+85]), 32'(0));

    // reset during the index phase drops everything
    drive(1'b1, {1'b0, 8'h50, 8'h55}, 1'b1, {1'b1, 8'h51, 8'h66}, t0);
    drive(1'b0, z, 1'b0, z, t);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("mrst we c2", 32'(tr[t0+2][10]), 32'(1));
    chk("mrst busy c3", 32'(bz_tr[t0+3]), 32'(0));
    chk("mrst ready c3", 32'(rd_tr[t0+3]), 32'(3));
    any_we = 1'b0;
    for (int i = 3; i <= 30; i++) if (tr[t0+i][10]) any_we = 1'b1;
    chk("mrst no we after", 32'(any_we), 32'(0));

    // backpressure on A while busy
    drive(1'b1, {1'b0, 8'h60, 8'h70}, 1'b0, z, t0);
    drive(1'b0, z, 1'b0, z, t);
    drive(1'b1, {1'b0, 8'h61, 8'h71}, 1'b0, z, t);
    drive(1'b1, {1'b1, 8'h62, 8'h72}, 1'b0, z, t);
    drive(1'b1, {1'b0, 8'h63, 8'h73}, 1'b0, z, t);
    drive(1'b1, {1'b1, 8'h64, 8'h74}, 1'b0, z, t);
    drive(1'b1, {1'b0, 8'h65, 8'h75}, 1'b0, z, t);
    acc = -1;
    for (int k = 0; k < 60 && acc < 0; k++) begin
      if (bus.a_ready) acc = cyc;
      else @(negedge clk);
    end
    drive(1'b0, z, 1'b0, z, t);
    chk("bp accept cycle", 32'(acc - t0), 32'(23));
    repeat (110) @(negedge clk);
    chk("bp ready c5", 32'(rd_tr[t0+5][1]), 32'(1));
    chk("bp ready c6", 32'(rd_tr[t0+6][1]), 32'(0));
    chk("bp ready c22", 32'(rd_tr[t0+22][1]), 32'(0));
    check_write("bp X",  t0 + 1,   2'd0, 2'd1, 8'h60, 8'h70, 0);
    check_write("bp Q1", t0 + 22,  2'd0, 2'd1, 8'h61, 8'h71, 0);
    check_write("bp Q2", t0 + 43,  2'd2, 2'd3, 8'h62, 8'h72, 0);
    check_write("bp Q3", t0 + 64,  2'd0, 2'd1, 8'h63, 8'h73, 0);
    check_write("bp Q4", t0 + 85,  2'd2, 2'd3, 8'h64, 8'h74, 0);
    check_write("bp Q5", t0 + 106, 2'd0, 2'd1, 8'h65, 8'h75, 0);
    chk("bp busy end", 32'(bz_tr[t0+127]), 32'(0));

    // repeated index back-to-back
    do_reset();
    drive(1'b1, {1'b0, 8'hB0, 8'h01}, 1'b0, z, t0);
    drive(1'b1, {1'b0, 8'hB0, 8'h02}, 1'b0, z, t);
    drive(1'b0, z, 1'b0, z, t);
    repeat (50) @(negedge clk);
    check_write("skip w1", t0 + 1, 2'd0, 2'd1, 8'hB0, 8'h01, 0);
`ifdef OPL3_WR_SCHED_SKIP_IDX_EN
    check_write("skip w2", t0 + 22, 2'd0, 2'd1, 8'hB0, 8'h02, 1);
    chk("skip busy c32", 32'(bz_tr[t0+32]), 32'(1));
    chk("skip busy c33", 32'(bz_tr[t0+33]), 32'(0));
`else
    check_write("skip w2", t0 + 22, 2'd0, 2'd1, 8'hB0, 8'h02, 0);
    chk("skip busy c42", 32'(bz_tr[t0+42]), 32'(1));
    chk("skip busy c43", 32'(bz_tr[t0+43]), 32'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
